// File: rtl/ldpc_syndrome_check.sv
// ldpc_syndrome_check
//   Accepts an LDPC codeword as NDATA+6 chunks of 27 bits (NDATA data chunks,
//   then six parity chunks). It accumulates the 162-bit syndrome
//   H * c^T from the per-chunk parity-check columns, buffers the data chunks,
//   and evaluates the syndrome once the whole codeword has been received.
//   It then streams the data chunks back out with the syndrome status attached.
//
// Ports
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : chunk input handshake
//   chunk_idx    : index of the chunk currently being accepted. The external
//                  loader answers it combinationally on h_col.
//   h_col        : 27 parity-check columns for the current chunk.
//                  h_col[i] belongs to in_data[i].
//   out_valid/out_ready/out_data/out_last : data chunk output handshake
//   syn_ok       : syndrome is all-zero
//   syn_weight   : popcount of the syndrome
//   frame_err    : in_last did not coincide with the final chunk
module ldpc_syndrome_check #(
  parameter int NDATA = 6,
  parameter int CHUNK = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK-1:0]        in_data,
  input  logic                    in_last,
  output logic [4:0]              chunk_idx,
  input  logic [CHUNK-1:0][161:0] h_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHUNK-1:0]        out_data,
  output logic                    out_last,
  output logic                    syn_ok,
  output logic [7:0]              syn_weight,
  output logic                    frame_err
);

  localparam int SYN_W = 162;
  localparam int KW = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [4:0]    LAST_IDX = 5'(NDATA + 5);
  localparam logic [4:0]    NDATA_5  = 5'(NDATA);
  localparam logic [KW-1:0] K_LAST   = KW'(NDATA - 1);

  typedef enum logic [1:0] {RECV, CHECK, SEND} state_t;

  function automatic logic [7:0] syn_popcount(input logic [SYN_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < SYN_W; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       chunk_idx_q, chunk_idx_d;
  logic [KW-1:0]    k_q, k_d, k_nxt;
  logic [SYN_W-1:0] syndrome_q, syndrome_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             syn_ok_q, syn_ok_d;
  logic [7:0]       syn_weight_q, syn_weight_d;
  logic             frame_err_q, frame_err_d;
  logic [CHUNK-1:0] out_data_q, out_data_d;
  logic [CHUNK-1:0] dbuf_q [NDATA];
  logic             dbuf_we;
  logic [SYN_W-1:0] contrib;

  // Syndrome contribution of the current chunk: XOR of the H columns
  // selected by the set bits of in_data.
  always_comb begin
    contrib = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (in_data[i]) contrib = contrib ^ h_col[i];
    end
  end

  assign k_nxt = k_q + KW'(1);

  always_comb begin
    state_d      = state_q;
    chunk_idx_d  = chunk_idx_q;
    k_d          = k_q;
    syndrome_d   = syndrome_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    syn_ok_d     = syn_ok_q;
    syn_weight_d = syn_weight_q;
    frame_err_d  = frame_err_q;
    out_data_d   = out_data_q;
    dbuf_we      = 1'b0;

    case (state_q)
      RECV: begin
        if (in_valid) begin
          syndrome_d  = syndrome_q ^ contrib;
          chunk_idx_d = chunk_idx_q + 5'd1;
          dbuf_we     = (chunk_idx_q < NDATA_5);
          // The frame length is fixed. in_last is used only to flag framing errors.
          if (chunk_idx_q == LAST_IDX) begin
            if (!in_last) frame_err_d = 1'b1;
            state_d = CHECK;
          end else if (in_last) begin
            frame_err_d = 1'b1;
          end
        end
      end
      CHECK: begin
        syn_ok_d     = (syndrome_q == '0);
        syn_weight_d = syn_popcount(syndrome_q);
        state_d      = SEND;
      end
      SEND: begin
        // The output register loads chunk 0 on the first SEND cycle.
        // After that it advances only on a handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = dbuf_q[k_q];
          out_last_d  = (k_q == K_LAST);
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            syndrome_d  = '0;
            chunk_idx_d = '0;
            k_d         = '0;
            frame_err_d = 1'b0;
            state_d     = RECV;
          end else begin
            k_d        = k_nxt;
            out_data_d = dbuf_q[k_nxt];
            out_last_d = (k_nxt == K_LAST);
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  // Control state. The syndrome is cleared on reset so that a new frame
  // always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RECV;
      chunk_idx_q  <= '0;
      k_q          <= '0;
      syndrome_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      syn_ok_q     <= 1'b0;
      syn_weight_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_idx_q  <= chunk_idx_d;
      k_q          <= k_d;
      syndrome_q   <= syndrome_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      syn_ok_q     <= syn_ok_d;
      syn_weight_q <= syn_weight_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Data storage has no reset. A buffer entry is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (dbuf_we) dbuf_q[chunk_idx_q[KW-1:0]] <= in_data;
    out_data_q <= out_data_d;
  end

  assign in_ready   = (state_q == RECV);
  assign chunk_idx  = chunk_idx_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign syn_ok     = syn_ok_q;
  assign syn_weight = syn_weight_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ldpc_syndrome_check.sv
module tb_ldpc_syndrome_check;

  localparam int NDATA = 6;
  localparam int CHUNK = 27;
  localparam int NCH   = NDATA + 6;
  localparam int CW_W  = NCH * CHUNK;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [CHUNK-1:0]        in_data = '0;
  logic                    in_last = 1'b0;
  logic [4:0]              chunk_idx;
  logic [CHUNK-1:0][161:0] h_col;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CHUNK-1:0]        out_data;
  logic                    out_last;
  logic                    syn_ok;
  logic [7:0]              syn_weight;
  logic                    frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  ldpc_syndrome_check #(.NDATA(NDATA), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .chunk_idx(chunk_idx), .h_col(h_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .syn_ok(syn_ok), .syn_weight(syn_weight), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Systematic H = [A | I]. Data columns are pseudo-random.
  // Parity column m is the unit vector e_m.
  function automatic logic [161:0] hcol(input int j);
    logic [161:0] v;
    v = '0;
    if (j < 162) begin
      for (int b = 0; b < 162; b++) v[b] = ((((j + 1) * (b + 3) + j) % 7) < 2);
    end else if (j < 324) begin
      v[j-162] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < CHUNK; i++) h_col[i] = hcol(int'(chunk_idx) * CHUNK + i);
  end

  function automatic int popc(input logic [161:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 162; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [161:0] make_data(input int pid);
    logic [161:0] d;
    for (int j = 0; j < 162; j++) begin
      case (pid)
        1:       d[j] = (((j * 5 + 3) % 7) < 3);
        2:       d[j] = (((j * 11 + 1) % 5) == 0);
        default: d[j] = 1'b0;
      endcase
    end
    return d;
  endfunction

  // Encoder: p = A*d, so the syndrome A*d ^ I*p is zero. flip < 0 means no error.
  function automatic logic [CW_W-1:0] build(input int pid, input int flip);
    logic [161:0]    d, p;
    logic [CW_W-1:0] cw;
    d = make_data(pid);
    p = '0;
    for (int j = 0; j < 162; j++) if (d[j]) p = p ^ hcol(j);
    cw = {p, d};
    if (flip >= 0) cw[flip] = ~cw[flip];
    return cw;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [CW_W-1:0] cw, input int last_pos, input int nch,
                      input bit keep_valid);
    int t;
    for (int c = 0; c < nch; c++) begin
      in_valid = 1'b1;
      in_data  = cw[c*CHUNK +: CHUNK];
      in_last  = (c == last_pos);
      t = 0;
      while (!in_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) chk("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic collect(input logic [CW_W-1:0] cw, input bit ok, input logic [7:0] w,
                         input bit ferr, input int stall_at, input string nm);
    int t;
    for (int k = 0; k < NDATA; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
          chk({nm, "_stall_data"}, 64'(out_data), 64'(cw[k*CHUNK +: CHUNK]));
          chk({nm, "_stall_inrdy"}, 64'(in_ready), 64'd0);
        end
      end
      out_ready = 1'b1;
      t = 0;
      while (!out_valid && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_data"}, 64'(out_data), 64'(cw[k*CHUNK +: CHUNK]));
      chk({nm, "_last"}, 64'(out_last), 64'(k == NDATA - 1));
      chk({nm, "_ok"}, 64'(syn_ok), 64'(ok));
      chk({nm, "_weight"}, 64'(syn_weight), 64'(w));
      chk({nm, "_ferr"}, 64'(frame_err), 64'(ferr));
      chk({nm, "_inrdy_low"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk({nm, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_post_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    string      nm;
    int         pid;
    int         flip;
    int         last_pos;
    int         stall_at;
    bit         ok;
    logic [7:0] w;
    bit         ferr;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [CW_W-1:0] cwa, cwb;

    tv[0] = '{"zero",      0, -1,      11, -1, 1'b1, 8'd0,            1'b0};
    tv[1] = '{"encA_stall",1, -1,      11,  2, 1'b1, 8'd0,            1'b0};
    tv[2] = '{"encA_flip3",1,  3,      11, -1, 1'b0, 8'(popc(hcol(3))), 1'b0};
    tv[3] = '{"early_last",1, -1,       4, -1, 1'b1, 8'd0,            1'b1};
    tv[4] = '{"par_flip",  2, 162 + 5, 11, -1, 1'b0, 8'd1,            1'b0};
    tv[5] = '{"no_last",   2, -1,      -1, -1, 1'b1, 8'd0,            1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_syn_ok", 64'(syn_ok), 64'd0);
    chk("rst_syn_weight", 64'(syn_weight), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_chunk_idx", 64'(chunk_idx), 64'd0);

    // Latency: the last transfer is at edge T. The bench samples 1 after T,
    // after T+1 and after T+2.
    cwa = build(1, -1);
    send(cwa, 11, NCH, 1'b0);
    chk("lat_t0_valid", 64'(out_valid), 64'd0);
    chk("lat_t0_inrdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("lat_t1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 64'(out_valid), 64'd1);
    collect(cwa, 1'b1, 8'd0, 1'b0, -1, "lat");

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      cwa = build(tv[v].pid, tv[v].flip);
      send(cwa, tv[v].last_pos, NCH, 1'b0);
      collect(cwa, tv[v].ok, tv[v].w, tv[v].ferr, tv[v].stall_at, tv[v].nm);
    end

    // Reset after chunk 7. The partial frame is discarded.
    cwb = build(2, -1);
    send(cwb, -1, 8, 1'b0);
    chk("mid_chunk_idx", 64'(chunk_idx), 64'd8);
    pulse_reset();
    chk("mid_rst_idx", 64'(chunk_idx), 64'd0);
    chk("mid_rst_inrdy", 64'(in_ready), 64'd1);
    cwa = build(1, -1);
    send(cwa, 11, NCH, 1'b0);
    collect(cwa, 1'b1, 8'd0, 1'b0, -1, "after_rst");

    // Reset during SEND.
    cwb = build(2, 30);
    send(cwb, 4, NCH, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("send_pre_valid", 64'(out_valid), 64'd1);
    pulse_reset();
    chk("send_rst_valid", 64'(out_valid), 64'd0);
    chk("send_rst_inrdy", 64'(in_ready), 64'd1);
    chk("send_rst_ok", 64'(syn_ok), 64'd0);
    chk("send_rst_weight", 64'(syn_weight), 64'd0);
    chk("send_rst_ferr", 64'(frame_err), 64'd0);
    cwa = build(0, -1);
    send(cwa, 11, NCH, 1'b0);
    collect(cwa, 1'b1, 8'd0, 1'b0, -1, "after_send_rst");

    // Two frames back to back with in_valid held high.
    cwa = build(1, -1);
    cwb = build(2, 162 + 5);
    fork
      begin
        send(cwa, 4, NCH, 1'b1);
        send(cwb, 11, NCH, 1'b0);
      end
      begin
        collect(cwa, 1'b1, 8'd0, 1'b1, -1, "b2b_1");
        collect(cwb, 1'b0, 8'd1, 1'b0, -1, "b2b_2");
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
